// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM state
// codes and ALU operation selects. The ALU-control decoder imports the same
// aluop constants so both sides agree on the meaning of 00/01/10.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

endpackage

// File: rtl/mc_control.sv
// Multi-cycle MIPS main control FSM.
//
// state  | meaning
// FETCH  | read instruction, PC <= PC+4 when memory completes
// DECODE | register read, branch target precompute, dispatch on opcode
// MEMADR | effective address for lw/sw
// MEMRD  | data memory read, waits on mem_ready
// MEMWB  | load result written to rt
// MEMWR  | data memory write, waits on mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | R-type result written to rd
// BRANCH | beq compare and conditional PC update
// JUMP   | PC <= jump target
// ADDIEX | addi ALU operation
// ADDIWB | addi result written to rt
// 12-15  | unused, recover to FETCH
module mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic [1:0]         aluop,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic               pcwrite,
    output logic               pcwritecond,
    output logic               iord,
    output logic               memread,
    output logic               memwrite,
    output logic               irwrite,
    output logic               memtoreg,
    output logic               regdst,
    output logic               regwrite,
    output logic [1:0]         pcsource,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t r_state;
    state_t w_next;

    logic w_pcwrite, w_pcwritecond, w_iord, w_memread, w_memwrite;
    logic w_irwrite, w_memtoreg, w_regdst, w_regwrite;
    logic w_instr_done, w_illegal_op;

    // State register; reset abandons whatever access was in flight.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    // Next-state and Moore outputs, with mem_ready gating in FETCH/MEMWR.
    always_comb begin
        w_next        = S_FETCH;
        aluop         = ALUOP_ADD;
        alusrca       = 1'b0;
        alusrcb       = SRCB_REGB;
        pcsource      = PCSRC_ALU;
        w_pcwrite     = 1'b0;
        w_pcwritecond = 1'b0;
        w_iord        = 1'b0;
        w_memread     = 1'b0;
        w_memwrite    = 1'b0;
        w_irwrite     = 1'b0;
        w_memtoreg    = 1'b0;
        w_regdst      = 1'b0;
        w_regwrite    = 1'b0;
        w_instr_done  = 1'b0;
        w_illegal_op  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                alusrcb   = SRCB_FOUR;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
                case (opcode)
                    OP_RTYPE:      w_next = S_EXEC;
                    OP_LW, OP_SW:  w_next = S_MEMADR;
                    OP_BEQ:        w_next = S_BRANCH;
                    OP_J:          w_next = S_JUMP;
                    OP_ADDI:       w_next = S_ADDIEX;
                    default: begin
                        w_next       = S_FETCH;
                        w_illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                if (opcode == OP_LW)      w_next = S_MEMRD;
                else if (opcode == OP_SW) w_next = S_MEMWR;
                else                      w_next = S_FETCH;
            end
            S_MEMRD: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
                w_next    = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_regwrite   = 1'b1;
                w_memtoreg   = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWR: begin
                w_memwrite   = 1'b1;
                w_iord       = 1'b1;
                w_instr_done = mem_ready;
                w_next       = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite   = 1'b1;
                w_regdst     = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BRANCH: begin
                alusrca       = 1'b1;
                aluop         = ALUOP_SUB;
                pcsource      = PCSRC_ALUOUT;
                w_pcwritecond = 1'b1;
                w_instr_done  = 1'b1;
            end
            S_JUMP: begin
                pcsource     = PCSRC_JUMP;
                w_pcwrite    = 1'b1;
                w_instr_done = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite   = 1'b1;
                w_instr_done = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Enables and pulses are held low for as long as reset is asserted.
    always_comb begin
        pcwrite     = w_pcwrite     & ~rst;
        pcwritecond = w_pcwritecond & ~rst;
        iord        = w_iord        & ~rst;
        memread     = w_memread     & ~rst;
        memwrite    = w_memwrite    & ~rst;
        irwrite     = w_irwrite     & ~rst;
        memtoreg    = w_memtoreg    & ~rst;
        regdst      = w_regdst      & ~rst;
        regwrite    = w_regwrite    & ~rst;
        instr_done  = w_instr_done  & ~rst;
        illegal_op  = w_illegal_op  & ~rst;
    end

    assign state = STATE_W'(r_state);

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter: STATE_W, 4, width of state output; no other parameters.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 opcode  in  6  instr[31:26] from instruction register, sampled in DECODE.
REQ-005 mem_ready  in  1  memory completes current read/write this cycle.
REQ-006 aluop  out  2  00 add, 01 sub, 10 use funct; drives the ALU-control decoder.
REQ-007 alusrca  out  1  0 PC, 1 register A.
REQ-008 alusrcb  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-009 pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite  out  1 each  standard multi-cycle datapath enables.
REQ-010 pcsource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
REQ-012 illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode.
REQ-013 state  out  STATE_W  current state encoding (debug/verification).

Function
REQ-014 States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11; codes 12-15 go to FETCH on the next edge.
REQ-015 FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00; irwrite=pcwrite=mem_ready; stays while mem_ready=0, else goes to DECODE.
REQ-016 DECODE: alusrca=0, alusrcb=11, aluop=00; next-state by opcode: 000000 EXEC, 100011/101011 MEMADR, 000100 BRANCH, 000010 JUMP, 001000 ADDIEX, other FETCH with illegal_op=1.
REQ-017 MEMADR: alusrca=1, alusrcb=10, aluop=00; goes to MEMRD for lw, MEMWR for sw (opcode held stable by IR).
REQ-018 MEMRD: memread=1, iord=1; waits on mem_ready=0, else goes to MEMWB.
REQ-019 MEMWB: regwrite=1, memtoreg=1, regdst=0, instr_done=1; goes to FETCH.
REQ-020 MEMWR: memwrite=1, iord=1; waits on mem_ready=0; instr_done=mem_ready; goes to FETCH when mem_ready=1.
REQ-021 EXEC: alusrca=1, alusrcb=00, aluop=10; goes to ALUWB. ALUWB: regwrite=1, regdst=1, memtoreg=0, instr_done=1; goes to FETCH.
REQ-022 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01, instr_done=1; goes to FETCH.
REQ-023 JUMP: pcwrite=1, pcsource=10, instr_done=1; goes to FETCH.
REQ-024 ADDIEX: alusrca=1, alusrcb=10, aluop=00; goes to ADDIWB. ADDIWB: regwrite=1, regdst=0, memtoreg=0, instr_done=1; goes to FETCH.
REQ-025 Any output not listed for a state is 0 in that state; outputs depend only on state, except the mem_ready gating in REQ-015 and REQ-020.
REQ-026 Zero-wait latency in cycles: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds exactly one cycle.

Reset
REQ-027 rst=1 at a rising edge sets state to FETCH regardless of current state; any pending memory access is abandoned.
REQ-028 While rst=1 all enable outputs, instr_done and illegal_op are forced to 0.
REQ-029 On the first cycle after rst deasserts, the block is in FETCH and asserts memread.

Structure
REQ-030 Shared package mips_ctrl_pkg holds the opcode constants, state encodings and aluop codes; the ALU-control decoder uses the same aluop constants.
REQ-031 Single module (state register plus combinational next-state and output decode); no sub-module.

Verification
REQ-032 Zero-wait R-type, opcode 000000, mem_ready=1 -> states 0,1,6,7; aluop=10 in EXEC; regwrite and regdst=1 and instr_done=1 in ALUWB; 4 cycles.
REQ-033 lw with mem_ready=0 for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4; memwrite never 1; regwrite and memtoreg=1 in MEMWB; 7 cycles.
REQ-034 beq -> states 0,1,8; aluop=01, pcwritecond=1, pcsource=01 in BRANCH; j -> pcwrite=1, pcsource=10 in JUMP.
REQ-035 Opcode 111111 -> illegal_op pulses for one cycle in DECODE; next state FETCH; no regwrite, memwrite or pcwrite.
REQ-036 rst=1 asserted in MEMWR with mem_ready=0 -> all enables 0 during reset; state=0 after the edge; memwrite not reasserted.
REQ-037 FETCH with mem_ready=0 for 3 cycles -> irwrite=pcwrite=0 in those cycles; both 1 only in the mem_ready=1 cycle.
